// File: rtl/ysyx_040750_ex_mem_buf.sv
// Two-entry EX->MEM skid buffer with registered ready toward the ALU,
// head-entry forwarding export and a saturating back-pressure counter.
module ysyx_040750_ex_mem_buf #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             I_sys_clk,
    input  logic             I_rst,
    input  logic             I_flush,
    input  logic             I_ex_valid,
    output logic             O_ex_ready,
    input  logic [XLEN-1:0]  I_pc,
    input  logic [XLEN-1:0]  I_result,
    input  logic [XLEN-1:0]  I_csr_data,
    input  logic [XLEN-1:0]  I_rs2_data,
    input  logic [4:0]       I_rd_addr,
    input  logic             I_rd_wen,
    input  logic [11:0]      I_csr_addr,
    input  logic             I_csr_wen,
    input  logic             I_mem_ren,
    input  logic             I_mem_wen,
    input  logic [7:0]       I_mem_mask,
    input  logic             I_load_sext,
    output logic             O_mem_valid,
    input  logic             I_mem_ready,
    output logic [XLEN-1:0]  O_pc,
    output logic [XLEN-1:0]  O_result,
    output logic [XLEN-1:0]  O_csr_data,
    output logic [XLEN-1:0]  O_rs2_data,
    output logic [4:0]       O_rd_addr,
    output logic             O_rd_wen,
    output logic [11:0]      O_csr_addr,
    output logic             O_csr_wen,
    output logic             O_mem_ren,
    output logic             O_mem_wen,
    output logic [7:0]       O_mem_mask,
    output logic             O_load_sext,
    output logic             O_fwd_valid,
    output logic [4:0]       O_fwd_rd_addr,
    output logic [XLEN-1:0]  O_fwd_data,
    output logic [CNT_W-1:0] O_stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] csr_data;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rd_addr;
        logic            rd_wen;
        logic [11:0]     csr_addr;
        logic            csr_wen;
        logic            mem_ren;
        logic            mem_wen;
        logic [7:0]      mem_mask;
        logic            load_sext;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    entry_t             m_q, m_d;
    entry_t             s_q, s_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    entry_t             in_e;
    logic               m_v, s_v, acc, deq;

    always_comb begin
        in_e.pc        = I_pc;
        in_e.result    = I_result;
        in_e.csr_data  = I_csr_data;
        in_e.rs2_data  = I_rs2_data;
        in_e.rd_addr   = I_rd_addr;
        in_e.rd_wen    = I_rd_wen;
        in_e.csr_addr  = I_csr_addr;
        in_e.csr_wen   = I_csr_wen;
        in_e.mem_ren   = I_mem_ren;
        in_e.mem_wen   = I_mem_wen;
        in_e.mem_mask  = I_mem_mask;
        in_e.load_sext = I_load_sext;
    end

    // Ready comes only from registered occupancy, never from I_mem_ready.
    assign m_v        = (state_q != ST_EMPTY);
    assign s_v        = (state_q == ST_FULL);
    assign O_ex_ready = ~I_rst & ~s_v;
    assign acc        = I_ex_valid & O_ex_ready;
    assign deq        = m_v & I_mem_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    m_d     = in_e;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                unique case ({acc, deq})
                    2'b11: m_d = in_e;
                    2'b10: begin
                        s_d     = in_e;
                        state_d = ST_FULL;
                    end
                    2'b01: state_d = ST_EMPTY;
                    default: ;
                endcase
            end
            ST_FULL: begin
                if (deq) begin
                    m_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Redirect kills both entries; payload registers keep stale data.
        if (I_flush) begin
            state_d = ST_EMPTY;
            m_d     = m_q;
            s_d     = s_q;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (I_ex_valid && !O_ex_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state_q     <= ST_EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign O_mem_valid   = m_v;
    assign O_pc          = m_q.pc;
    assign O_result      = m_q.result;
    assign O_csr_data    = m_q.csr_data;
    assign O_rs2_data    = m_q.rs2_data;
    assign O_rd_addr     = m_q.rd_addr;
    assign O_rd_wen      = m_q.rd_wen;
    assign O_csr_addr    = m_q.csr_addr;
    assign O_csr_wen     = m_q.csr_wen;
    assign O_mem_ren     = m_q.mem_ren;
    assign O_mem_wen     = m_q.mem_wen;
    assign O_mem_mask    = m_q.mem_mask;
    assign O_load_sext   = m_q.load_sext;
    assign O_fwd_valid   = m_v & m_q.rd_wen & (m_q.rd_addr != 5'd0);
    assign O_fwd_rd_addr = m_q.rd_addr;
    assign O_fwd_data    = m_q.result;
    assign O_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_040750_ex_mem_buf.sv
// Directed plus random bench for the EX->MEM skid buffer against a queue model.
module tb_ysyx_040750_ex_mem_buf;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 4;
    localparam int          CNT_MAX = 15;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] result;
        logic [63:0] csr_data;
        logic [63:0] rs2_data;
        logic [4:0]  rd_addr;
        logic        rd_wen;
        logic [11:0] csr_addr;
        logic        csr_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [7:0]  mem_mask;
        logic        load_sext;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, flush = 1'b0, ex_valid = 1'b0, mem_ready = 1'b0;
    ent_t cur = '0;

    logic             o_ex_ready, o_mem_valid, o_rd_wen, o_csr_wen, o_mem_ren, o_mem_wen, o_load_sext;
    logic             o_fwd_valid;
    logic [XLEN-1:0]  o_pc, o_result, o_csr_data, o_rs2_data, o_fwd_data;
    logic [4:0]       o_rd_addr, o_fwd_rd_addr;
    logic [11:0]      o_csr_addr;
    logic [7:0]       o_mem_mask;
    logic [CNT_W-1:0] o_stall_cnt;

    ysyx_040750_ex_mem_buf #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .I_sys_clk(clk), .I_rst(rst), .I_flush(flush),
        .I_ex_valid(ex_valid), .O_ex_ready(o_ex_ready),
        .I_pc(cur.pc), .I_result(cur.result), .I_csr_data(cur.csr_data),
        .I_rs2_data(cur.rs2_data), .I_rd_addr(cur.rd_addr), .I_rd_wen(cur.rd_wen),
        .I_csr_addr(cur.csr_addr), .I_csr_wen(cur.csr_wen), .I_mem_ren(cur.mem_ren),
        .I_mem_wen(cur.mem_wen), .I_mem_mask(cur.mem_mask), .I_load_sext(cur.load_sext),
        .O_mem_valid(o_mem_valid), .I_mem_ready(mem_ready),
        .O_pc(o_pc), .O_result(o_result), .O_csr_data(o_csr_data), .O_rs2_data(o_rs2_data),
        .O_rd_addr(o_rd_addr), .O_rd_wen(o_rd_wen), .O_csr_wen(o_csr_wen),
        .O_mem_ren(o_mem_ren), .O_mem_wen(o_mem_wen), .O_load_sext(o_load_sext),
        .O_csr_addr(o_csr_addr), .O_mem_mask(o_mem_mask),
        .O_fwd_valid(o_fwd_valid), .O_fwd_rd_addr(o_fwd_rd_addr), .O_fwd_data(o_fwd_data),
        .O_stall_cnt(o_stall_cnt)
    );

    // Reference model: an in-order queue of at most two accepted bundles.
    ent_t q[$];
    int   cnt = 0;
    bit   zero_fields = 1'b1;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [63:0] r);
        ent_t e;
        e.pc        = {$urandom, $urandom};
        e.result    = r;
        e.csr_data  = {$urandom, $urandom};
        e.rs2_data  = {$urandom, $urandom};
        e.rd_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        e.rd_wen    = 1'($urandom);
        e.csr_addr  = 12'($urandom);
        e.csr_wen   = 1'($urandom);
        e.mem_ren   = 1'($urandom);
        e.mem_wen   = 1'($urandom);
        e.mem_mask  = 8'($urandom);
        e.load_sext = 1'($urandom);
        return e;
    endfunction

    task automatic check_all();
        bit exp_ready;
        exp_ready = !rst && (q.size() < 2);
        chk("ex_ready", 64'(o_ex_ready), 64'(exp_ready));
        chk("mem_valid", 64'(o_mem_valid), 64'(q.size() > 0));
        chk("stall_cnt", 64'(o_stall_cnt), 64'(cnt));
        if (q.size() > 0) begin
            chk("pc", o_pc, q[0].pc);
            chk("result", o_result, q[0].result);
            chk("csr_data", o_csr_data, q[0].csr_data);
            chk("rs2_data", o_rs2_data, q[0].rs2_data);
            chk("ctrl", 64'({o_rd_addr, o_rd_wen, o_csr_addr, o_csr_wen, o_mem_ren,
                             o_mem_wen, o_mem_mask, o_load_sext}),
                64'({q[0].rd_addr, q[0].rd_wen, q[0].csr_addr, q[0].csr_wen, q[0].mem_ren,
                     q[0].mem_wen, q[0].mem_mask, q[0].load_sext}));
            chk("fwd_valid", 64'(o_fwd_valid), 64'(q[0].rd_wen && (q[0].rd_addr != 5'd0)));
            chk("fwd_rd_addr", 64'(o_fwd_rd_addr), 64'(q[0].rd_addr));
            chk("fwd_data", o_fwd_data, q[0].result);
        end else begin
            chk("fwd_valid_empty", 64'(o_fwd_valid), 64'd0);
            if (zero_fields) begin
                chk("result_zero", o_result, 64'd0);
                chk("pc_zero", o_pc, 64'd0);
            end
        end
    endtask

    // One clock: model sees the inputs held across the edge, then outputs are checked.
    task automatic cycle();
        bit rdy;
        @(posedge clk);
        rdy = !rst && (q.size() < 2);
        if (rst) begin
            q.delete();
            cnt = 0;
            zero_fields = 1'b1;
        end else begin
            if (ex_valid && !rdy && cnt < CNT_MAX) cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && mem_ready) void'(q.pop_front());
                if (ex_valid && rdy) begin
                    q.push_back(cur);
                    zero_fields = 1'b0;
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        // Reset, then stream three results with MEM always ready.
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(o_ex_ready), 64'd1);
        mem_ready = 1'b1;
        ex_valid  = 1'b1;
        cur = mk(64'h10); cycle();
        chk("stream_0x10", o_result, 64'h10);
        cur = mk(64'h20); cycle();
        chk("stream_0x20", o_result, 64'h20);
        cur = mk(64'h30); cycle();
        chk("stream_0x30", o_result, 64'h30);
        ex_valid = 1'b0;
        cycle();

        // Back-pressure fill, third push refused.
        mem_ready = 1'b0;
        ex_valid  = 1'b1;
        cur = mk(64'hA); cycle();
        cur = mk(64'hB); cycle();
        chk("full_not_ready", 64'(o_ex_ready), 64'd0);
        cur = mk(64'hC); cycle();
        cycle();
        chk("held_0xA", o_result, 64'hA);
        chk("stall_two", 64'(o_stall_cnt), 64'd2);
        ex_valid = 1'b0;

        // Drain in order.
        mem_ready = 1'b1;
        cycle();
        chk("drain_0xB", o_result, 64'hB);
        chk("ready_back", 64'(o_ex_ready), 64'd1);
        cycle();
        chk("drained", 64'(o_mem_valid), 64'd0);

        // Flush while full with a valid input present.
        mem_ready = 1'b0;
        ex_valid  = 1'b1;
        cur = mk(64'h1A); cycle();
        cur = mk(64'h1B); cycle();
        cur = mk(64'h1E);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        ex_valid = 1'b0;
        chk("flush_empty", 64'(o_mem_valid), 64'd0);
        chk("flush_ready", 64'(o_ex_ready), 64'd1);
        cycle();

        // Forwarding export.
        mem_ready = 1'b1;
        ex_valid  = 1'b1;
        cur = mk(64'hDEAD); cur.rd_addr = 5'd5; cur.rd_wen = 1'b1;
        cycle();
        chk("fwd_on", 64'(o_fwd_valid), 64'd1);
        chk("fwd_rd5", 64'(o_fwd_rd_addr), 64'd5);
        chk("fwd_dead", o_fwd_data, 64'hDEAD);
        cur = mk(64'hDEAD); cur.rd_addr = 5'd0; cur.rd_wen = 1'b1;
        cycle();
        chk("fwd_x0", 64'(o_fwd_valid), 64'd0);
        ex_valid = 1'b0;
        cycle();

        // Reset with the buffer full.
        mem_ready = 1'b0;
        ex_valid  = 1'b1;
        cur = mk(64'h55); cycle();
        cur = mk(64'h66); cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid_valid", 64'(o_mem_valid), 64'd0);
        chk("rst_mid_cnt", 64'(o_stall_cnt), 64'd0);
        chk("rst_mid_result", o_result, 64'd0);

        // Counter saturation: fill, then keep pushing.
        for (int i = 0; i < 20; i++) begin
            cur = mk(64'(i));
            cycle();
        end
        chk("stall_sat", 64'(o_stall_cnt), 64'd15);
        ex_valid = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            ex_valid  = ($urandom_range(0, 3) != 0);
            mem_ready = 1'($urandom);
            cur       = mk({$urandom, $urandom});
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
